// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one register-bus port among NREQ requesters;
// serialises reads/writes and returns fixed-latency read data to the owner.
module reg_access_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_we,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_rvalid,
  output logic [DW-1:0]      o_rdata,
  output logic [NREQ-1:0]    o_err,
  output logic [AW-1:0]      o_reg_addr,
  output logic [DW-1:0]      o_reg_wdata,
  output logic               o_reg_we,
  output logic               o_reg_re,
  input  logic [DW-1:0]      i_reg_rdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic            r_we;
  logic            r_oor;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_rvalid;
  logic [NREQ-1:0] r_err;
  logic [DW-1:0]   r_rdata;
  logic [AW-1:0]   r_reg_addr;
  logic [DW-1:0]   r_reg_wdata;
  logic            r_reg_we;
  logic            r_reg_re;

  state_t          w_state_nxt;
  logic [IW-1:0]   w_ptr_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic            w_we_nxt;
  logic            w_oor_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [NREQ-1:0] w_rvalid_nxt;
  logic [NREQ-1:0] w_err_nxt;
  logic [DW-1:0]   w_rdata_nxt;
  logic [AW-1:0]   w_reg_addr_nxt;
  logic [DW-1:0]   w_reg_wdata_nxt;
  logic            w_reg_we_nxt;
  logic            w_reg_re_nxt;

  logic [IW-1:0]   w_win;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_wdata;
  logic            w_win_we;
  logic            w_win_oor;

  // Requester index at offset 'off' from 'base', wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base,
                                           input int unsigned off);
    int unsigned j;
    j = 32'(base) + off;
    if (j >= NREQ) j = j - NREQ;
    return IW'(j);
  endfunction

  // Round-robin winner: first requesting index at or after r_ptr.
  always_comb begin
    w_win = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (i_req[rr_idx(r_ptr, k - 1)]) w_win = rr_idx(r_ptr, k - 1);
    end
  end

  assign w_win_addr  = i_addr[32'(w_win)*AW +: AW];
  assign w_win_wdata = i_wdata[32'(w_win)*DW +: DW];
  assign w_win_we    = i_we[w_win];
  assign w_win_oor   = (w_win_addr >= AW'(DEPTH));

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_idx_nxt       = r_idx;
    w_we_nxt        = r_we;
    w_oor_nxt       = r_oor;
    w_cnt_nxt       = r_cnt;
    w_gnt_nxt       = '0;
    w_rvalid_nxt    = '0;
    w_err_nxt       = '0;
    w_rdata_nxt     = r_rdata;
    w_reg_addr_nxt  = r_reg_addr;
    w_reg_wdata_nxt = r_reg_wdata;
    w_reg_we_nxt    = 1'b0;
    w_reg_re_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_state_nxt      = ST_ISSUE;
          w_idx_nxt        = w_win;
          w_we_nxt         = w_win_we;
          w_oor_nxt        = w_win_oor;
          w_ptr_nxt        = (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);
          w_gnt_nxt[w_win] = 1'b1;
          if (!w_win_oor) begin
            w_reg_addr_nxt  = w_win_addr;
            w_reg_wdata_nxt = w_win_wdata;
            w_reg_we_nxt    = w_win_we;
            w_reg_re_nxt    = !w_win_we;
          end else begin
            // Write errors pulse with gnt; read errors wait for rvalid.
            w_err_nxt[w_win] = w_win_we;
          end
        end
      end

      ST_ISSUE: begin
        if (r_we) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end

      ST_WAIT: begin
        if (r_cnt == CW'(RD_LAT)) begin
          w_state_nxt          = ST_IDLE;
          w_cnt_nxt            = '0;
          w_rdata_nxt          = r_oor ? '0 : i_reg_rdata;
          w_rvalid_nxt[r_idx]  = 1'b1;
          w_err_nxt[r_idx]     = r_oor;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_idx       <= w_idx_nxt;
      r_we        <= w_we_nxt;
      r_oor       <= w_oor_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_reg_we    <= w_reg_we_nxt;
      r_reg_re    <= w_reg_re_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rvalid    = r_rvalid;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_we    = r_reg_we;
  assign o_reg_re    = r_reg_re;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter: vector table, corner-case
// sequences, and randomized traffic against a transaction-level model.
module tb_reg_access_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned DAW    = 6;
  localparam int unsigned RD_LAT = 2;
  localparam int          MAXC   = 2048;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req, we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt, rvalid, err;
  logic [DW-1:0]      rdata, reg_wdata, reg_rdata;
  logic [AW-1:0]      reg_addr;
  logic               reg_we, reg_re;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] last_rd;

  reg_access_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_err(err),
    .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata),
    .o_reg_we(reg_we), .o_reg_re(reg_re), .i_reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  // Register module model: memory plus RD_LAT-deep read pipeline.
  logic [DW-1:0] bus_mem [DEPTH];
  logic          pv [RD_LAT];
  logic [DW-1:0] pd [RD_LAT];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bus_mem[i] <= DW'(i) ^ 8'h3F;
      for (int i = 0; i < RD_LAT; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
    end else begin
      if (reg_we && reg_addr < DEPTH) bus_mem[reg_addr[DAW-1:0]] <= reg_wdata;
      pv[0] <= reg_re;
      pd[0] <= (reg_addr < DEPTH) ? bus_mem[reg_addr[DAW-1:0]] : 8'hEE;
      for (int i = 1; i < RD_LAT; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
    end
  end
  assign reg_rdata = pv[RD_LAT-1] ? pd[RD_LAT-1] : 8'hEE;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    tick(); tick();
    chk({tag, " reset outputs"},
        64'({gnt, rvalid, err, rdata, reg_addr, reg_wdata, reg_we, reg_re}), 64'd0);
    rst_n   = 1'b1;
    last_rd = '0;
  endtask

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    int            idx;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            oor;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl[10];

  task automatic apply_vec(input vec_t v, input int k);
    logic [NREQ-1:0] oh;
    string nm;
    oh = '0;
    oh[v.idx] = 1'b1;
    nm = $sformatf("vec%0d", k);
    req = '0;
    set_req(v.idx, v.w, v.a, v.d);
    tick();
    chk({nm, " gnt"}, 64'(gnt), 64'(oh));
    chk({nm, " err@gnt"}, 64'(err), (v.w && v.oor) ? 64'(oh) : 64'd0);
    chk({nm, " reg_we"}, 64'(reg_we), 64'(v.w && !v.oor));
    chk({nm, " reg_re"}, 64'(reg_re), 64'(!v.w && !v.oor));
    if (!v.oor) begin
      chk({nm, " reg_addr"}, 64'(reg_addr), 64'(v.a));
      chk({nm, " reg_wdata"}, 64'(reg_wdata), 64'(v.d));
    end
    req = '0;
    if (!v.w) begin
      for (int c = 0; c < RD_LAT; c++) begin
        tick();
        chk({nm, " early rvalid"}, 64'(rvalid), 64'd0);
      end
      tick();
      chk({nm, " rvalid"}, 64'(rvalid), 64'(oh));
      chk({nm, " rdata"}, 64'(rdata), 64'(v.rd));
      chk({nm, " err@rvalid"}, 64'(err), v.oor ? 64'(oh) : 64'd0);
      last_rd = v.rd;
    end
    tick();
    chk({nm, " idle pulses"}, 64'({gnt, rvalid, err, reg_we, reg_re}), 64'd0);
    chk({nm, " rdata hold"}, 64'(rdata), 64'(last_rd));
  endtask

  // ---------------- randomized traffic vs. transaction model ----------------
  logic [NREQ-1:0] e_gnt [MAXC];
  logic [NREQ-1:0] e_err [MAXC];
  logic [NREQ-1:0] e_rv  [MAXC];
  logic            e_we  [MAXC];
  logic            e_re  [MAXC];
  logic [AW-1:0]   e_addr[MAXC];
  logic [DW-1:0]   e_wd  [MAXC];
  logic [DW-1:0]   e_rd  [MAXC];
  logic [DW-1:0]   ref_mem[DEPTH];

  task automatic run_random(input int ncyc, input bit force2, input string tag);
    int free_at, mptr, w, j, r;
    int waits[NREQ];
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit oor;
    for (int c = 0; c < MAXC; c++) begin
      e_gnt[c] = '0; e_err[c] = '0; e_rv[c] = '0; e_we[c] = 1'b0; e_re[c] = 1'b0;
      e_addr[c] = '0; e_wd[c] = '0; e_rd[c] = '0;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = bus_mem[i];
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    free_at = 0;
    mptr    = 0;
    for (int n = 0; n < ncyc + 40; n++) begin
      chk($sformatf("%s gnt @%0d", tag, n), 64'(gnt), 64'(e_gnt[n]));
      chk($sformatf("%s err @%0d", tag, n), 64'(err), 64'(e_err[n]));
      chk($sformatf("%s rvalid @%0d", tag, n), 64'(rvalid), 64'(e_rv[n]));
      chk($sformatf("%s strobes @%0d", tag, n), 64'({reg_we, reg_re}), 64'({e_we[n], e_re[n]}));
      if (e_we[n] || e_re[n]) begin
        chk($sformatf("%s reg_addr @%0d", tag, n), 64'(reg_addr), 64'(e_addr[n]));
        chk($sformatf("%s reg_wdata @%0d", tag, n), 64'(reg_wdata), 64'(e_wd[n]));
      end
      if (e_rv[n] != '0)
        chk($sformatf("%s rdata @%0d", tag, n), 64'(rdata), 64'(e_rd[n]));
      // Fairness: each pending requester sees at most NREQ-1 other grants.
      if (gnt != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req[i]) begin
            if (gnt[i]) begin
              chk($sformatf("%s fairness req%0d rounds=%0d", tag, i, waits[i] + 1),
                  64'(waits[i] > int'(NREQ) - 1), 64'd0);
              waits[i] = 0;
            end else begin
              waits[i]++;
            end
          end
        end
      end
      for (int i = 0; i < NREQ; i++) if (gnt[i]) req[i] = 1'b0;
      if (n < ncyc) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i] && ((force2 && i == 2) || $urandom_range(0, 3) == 0)) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'hFFFF_FFFF;
            else if (r == 1) a = 32'(DEPTH + $urandom_range(0, 200));
            else             a = 32'($urandom_range(0, DEPTH - 1));
            set_req(i, 1'($urandom_range(0, 1)), a, 8'($urandom));
          end
        end
      end
      // Model: an idle arbiter with requests grants the next one after mptr.
      if (n >= free_at && req != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          j = (mptr + k) % NREQ;
          if (w < 0 && req[j]) w = j;
        end
        a   = addr[w*AW +: AW];
        d   = wdata[w*DW +: DW];
        oor = (a >= DEPTH);
        e_gnt[n+1][w] = 1'b1;
        if (!oor) begin
          e_we[n+1]   = we[w];
          e_re[n+1]   = !we[w];
          e_addr[n+1] = a;
          e_wd[n+1]   = d;
        end
        if (we[w]) begin
          if (oor) e_err[n+1][w] = 1'b1;
          else     ref_mem[a[DAW-1:0]] = d;
          free_at = n + 2;
        end else begin
          e_rv[n+2+RD_LAT][w]  = 1'b1;
          e_err[n+2+RD_LAT][w] = oor;
          e_rd[n+2+RD_LAT]     = oor ? '0 : ref_mem[a[DAW-1:0]];
          free_at = n + 2 + RD_LAT;
        end
        mptr = (w + 1) % NREQ;
      end
      tick();
    end
    req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] exp_g;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; last_rd = '0;

    tbl[0] = '{0, 1'b1, 32'd5,          8'hA5, 1'b0, 8'h00};
    tbl[1] = '{1, 1'b0, 32'd3,          8'h00, 1'b0, 8'h3C};
    tbl[2] = '{0, 1'b1, 32'd64,         8'h11, 1'b1, 8'h00};
    tbl[3] = '{1, 1'b0, 32'hFFFF_FFFF,  8'h00, 1'b1, 8'h00};
    tbl[4] = '{2, 1'b1, 32'd63,         8'h5A, 1'b0, 8'h00};
    tbl[5] = '{2, 1'b0, 32'd63,         8'h00, 1'b0, 8'h5A};
    tbl[6] = '{0, 1'b0, 32'd5,          8'h00, 1'b0, 8'hA5};
    tbl[7] = '{1, 1'b0, 32'd0,          8'h00, 1'b0, 8'h3F};
    tbl[8] = '{1, 1'b1, 32'h8000_0003,  8'h99, 1'b1, 8'h00};
    tbl[9] = '{2, 1'b0, 32'd3,          8'h00, 1'b0, 8'h3C};

    do_reset("init");
    for (int k = 0; k < 10; k++) apply_vec(tbl[k], k);

    // Contention: two writers held continuously alternate every 2 cycles.
    do_reset("contention");
    set_req(0, 1'b1, 32'd10, 8'h11);
    set_req(1, 1'b1, 32'd20, 8'h22);
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) req = '0;
      tick();
      exp_g = '0;
      if (k % 2 == 1) exp_g[((k - 1) / 2) % 2] = 1'b1;
      chk($sformatf("contention gnt cyc%0d", k), 64'(gnt), 64'(exp_g));
    end

    // Reset mid-read: read discarded, pointer back to 0.
    do_reset("midread");
    set_req(1, 1'b0, 32'd3, 8'h00);
    tick();
    chk("midread gnt", 64'(gnt), 64'(3'b010));
    chk("midread reg_re", 64'(reg_re), 64'd1);
    req = '0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midread reset outputs",
        64'({gnt, rvalid, err, rdata, reg_addr, reg_wdata, reg_we, reg_re}), 64'd0);
    rst_n = 1'b1;
    set_req(1, 1'b1, 32'd1, 8'h77);
    set_req(2, 1'b1, 32'd2, 8'h66);
    tick();
    chk("post-reset ptr order gnt", 64'(gnt), 64'(3'b010));
    chk("post-reset rvalid", 64'(rvalid), 64'd0);
    req[1] = 1'b0;
    tick();
    chk("post-reset idle gnt", 64'(gnt | rvalid), 64'd0);
    tick();
    chk("post-reset second gnt", 64'(gnt), 64'(3'b100));
    req = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("discarded read rvalid +%0d", c), 64'(rvalid), 64'd0);
    end

    do_reset("random");
    run_random(700, 1'b0, "rnd");
    do_reset("fair");
    run_random(400, 1'b1, "fair");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Round-robin arbiter that shares the single register-module access port (addr/data) among NREQ requesters, such as the test generator and the TEST2 datapath. It serialises requester reads and writes onto the register bus, tracks read latency, and routes read data back to the owning requester. It sits in the top level between the requesting instances and the register module.

## Interface

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width
- DW, 8, data width
- DEPTH, 64, number of valid register addresses; addr >= DEPTH is out of range
- RD_LAT, 1, register-module read latency in cycles (1..4; 0 not supported)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester request; held until gnt
- we  in  NREQ  per-requester write (1) / read (0); held with req
- addr  in  NREQ*AW  per-requester address, slice i at [i*AW +: AW]; held with req
- wdata  in  NREQ*DW  per-requester write data, slice i; held with req
- gnt  out  NREQ  one-hot one-cycle pulse: request accepted
- rvalid  out  NREQ  one-hot one-cycle pulse: rdata valid for that requester
- rdata  out  DW  shared read-return data
- err  out  NREQ  one-cycle pulse, coincident with gnt (write) or rvalid (read), for an out-of-range address
- reg_addr  out  AW  register bus address
- reg_wdata  out  DW  register bus write data
- reg_we  out  1  register bus write strobe
- reg_re  out  1  register bus read strobe
- reg_rdata  in  DW  register bus read data, valid RD_LAT cycles after the reg_re cycle

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req bit is high, select the winner by round-robin, register the winner's index, we, addr and wdata, and go to ISSUE. Otherwise stay in IDLE.
- Round-robin: search starts at ptr and wraps modulo NREQ. After a grant, ptr becomes winner+1 (wrapping NREQ-1 to 0). ptr resets to 0.
- ISSUE (1 cycle):
  - gnt[winner]=1.
  - In range: drive reg_addr and reg_wdata, and assert reg_we (write) or reg_re (read).
  - Out of range: no strobe is asserted.
  - Write next state: IDLE, with err[winner]=1 if out of range.
  - Read next state: WAIT. Out-of-range reads also go to WAIT to keep latency fixed.
- WAIT: a counter runs from 1 to RD_LAT. At count RD_LAT, sample reg_rdata (forced to 0 if out of range) into rdata and go to IDLE.
- rvalid[winner] and err (for out-of-range reads) pulse in the first IDLE cycle after WAIT. rdata holds its value until the next read completes.
- Requests arriving in ISSUE or WAIT are not evaluated until IDLE. Only one transaction is ever in flight.
- A requester that drops req before gnt is a protocol violation; behaviour is undefined, but the FSM must still return to IDLE.
- Address range check: the full AW-bit addr is compared unsigned against DEPTH. reg_addr carries the full AW bits.
- Reset (any state, including mid-read):
  - FSM goes to IDLE, ptr=0, WAIT counter=0.
  - gnt, rvalid and err are 0; reg_we and reg_re are 0; reg_addr, reg_wdata and rdata are 0.
  - An in-flight read is discarded and produces no rvalid.

## Timing

- All outputs are registered. Reset value of every output is 0.
- req seen high in IDLE at cycle T: ISSUE, gnt and strobe at T+1.
- Write: IDLE again at T+2. Back-to-back write throughput is 1 per 2 cycles.
- Read: reg_rdata is sampled at T+1+RD_LAT. rvalid and rdata are valid at T+2+RD_LAT. With RD_LAT=1, rvalid is at T+3.
- The earliest next ISSUE after a read is T+3+RD_LAT: the IDLE cycle that carries rvalid also arbitrates.
- reg_we and reg_re are never high together and each is high for at most 1 cycle per transaction.
- gnt, rvalid and err are each at most one-hot.

## Test plan

- Single write: requester 0 writes addr=5, wdata=0xA5.
  - gnt[0] at T+1 together with reg_we=1, reg_addr=5, reg_wdata=0xA5.
  - No rvalid and no err.
- Single read, RD_LAT=2: requester 1 reads addr=3; the register model returns 0x3C.
  - reg_re at T+1.
  - rvalid[1]=1 and rdata=0x3C at T+4.
  - rvalid[0] stays 0.
- Contention: req=2'b11 held continuously with both requesters writing.
  - Grants alternate 0,1,0,1 on consecutive ISSUE cycles, spaced 2 cycles apart.
  - ptr wraps from 1 to 0.
- Out of range with DEPTH=64:
  - Write to addr=64: gnt plus err pulse, reg_we stays 0.
  - Read from addr=0xFFFFFFFF: rvalid and err pulse, rdata=0x00, reg_re stays 0.
- Reset mid-read: assert rst_n=0 during WAIT.
  - Next cycle: all outputs 0, no rvalid is ever produced for that read.
  - After release, a req on requester 1 is granted with ptr=0 search order.
- NREQ=3 fairness: requester 2 held high while requesters 0 and 1 toggle randomly.
  - Requester 2 is granted within 3 arbitration rounds, every time.
